// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared opcodes, FSM/iterator enums and the single-cycle
// result/flag helper for the multicycle ALU.
// Optional feature macro: ALU_MC_MUL_EN (iterative multiply on op 11).
package alu_mc_pkg;

  // Widest datapath the single-cycle helper supports.
  localparam int MAXW = 64;

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_NOT = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    IT_SLL = 2'd0,
    IT_SRL = 2'd1,
    IT_SRA = 2'd2,
    IT_MUL = 2'd3
  } iter_mode_t;

  // legal=0 marks an opcode with no defined operation: all flags clear.
  typedef struct packed {
    logic [MAXW:0] res;
    logic          carry;
    logic          ovf;
    logic          legal;
  } alu_fn_t;

  // Single-cycle result and flags. Operands arrive zero-extended to MAXW+1
  // bits; w is the real datapath width, so bit w of the sum is the carry-out
  // and bit w-1 is the sign. Shift opcodes only reach this with amount 0.
  function automatic alu_fn_t alu_single(input logic [3:0]    op,
                                         input logic [MAXW:0] a,
                                         input logic [MAXW:0] b,
                                         input logic [6:0]    w);
    alu_fn_t       r;
    logic [MAXW:0] s;
    logic [MAXW:0] d;
    logic [6:0]    sb;
    r     = '0;
    s     = a + b;
    d     = a - b;
    sb    = w - 7'd1;
    r.legal = 1'b1;
    case (op)
      OP_MOV: r.res = a;
      OP_NOT: r.res = ~a;
      OP_ADD: begin
        r.res   = s;
        r.carry = s[w];
        r.ovf   = (a[sb] == b[sb]) && (s[sb] != a[sb]);
      end
      OP_SUB: begin
        r.res   = d;
        r.carry = (a < b);
        r.ovf   = (a[sb] != b[sb]) && (d[sb] != a[sb]);
      end
      OP_OR:  r.res = a | b;
      OP_AND: r.res = a & b;
      OP_SLT: r.res = {{MAXW{1'b0}}, (a < b)};
      OP_XOR: r.res = a ^ b;
      OP_SLL, OP_SRL, OP_SRA: r.res = a;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: working registers for multicycle ops (shift one bit per step,
// or one shift-add multiply step). o_acc_next is the value the accumulator
// takes on the current step, so the top can capture the final result on the
// same edge o_last is seen.
// Optional feature macro: ALU_MC_MUL_EN (multiplicand/multiplier registers).
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  iter_mode_t       i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [CW-1:0]    i_cnt,
  output logic [WIDTH-1:0] o_acc_next,
  output logic             o_last
);

  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  iter_mode_t       r_mode;
  logic [WIDTH-1:0] w_acc_next;

`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
`endif

  // One step of the selected operation on the accumulator.
  always_comb begin
    w_acc_next = r_acc;
    case (r_mode)
      IT_SLL: w_acc_next = {r_acc[WIDTH-2:0], 1'b0};
      IT_SRL: w_acc_next = {1'b0, r_acc[WIDTH-1:1]};
      IT_SRA: w_acc_next = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
`ifdef ALU_MC_MUL_EN
      IT_MUL: w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif
      default: w_acc_next = r_acc;
    endcase
  end

  // Load operands on accept, advance one step per EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_mode <= IT_SLL;
    end else if (i_load) begin
      r_acc  <= (i_mode == IT_MUL) ? '0 : i_a;
      r_cnt  <= i_cnt;
      r_mode <= i_mode;
    end else if (i_step) begin
      r_acc  <= w_acc_next;
      r_cnt  <= r_cnt - CW'(1);
    end
  end

`ifdef ALU_MC_MUL_EN
  // Multiplicand walks left, multiplier walks right, one bit per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (i_step) begin
      r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
    end
  end
`endif

  assign o_acc_next = w_acc_next;
  assign o_last     = (r_cnt == CW'(1));

endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked multicycle ALU. One op per in_valid/in_ready transfer;
// the registered result and flags are held in DONE until out_ready.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is high only in IDLE, out_valid only in DONE, and each
// side ignores its request input while the other side's state is active.
// Optional feature macro: ALU_MC_MUL_EN (op 11 is an iterative multiply;
// otherwise op 11 is illegal: result 0, flags 0, one-cycle latency).
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op_code,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_carry,
  output logic             o_overflow,
  output state_t           o_dbg_state
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;

  alu_fn_t          w_fn;
  logic [WIDTH-1:0] w_fn_res;
  logic [SHW-1:0]   w_amt;
  logic             w_is_shift;
  logic             w_is_mul;
  logic             w_multi;
  iter_mode_t       w_mode;
  logic [CW-1:0]    w_cnt;
  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_fn     = alu_single(i_op_code, (MAXW+1)'(i_a), (MAXW+1)'(i_b), 7'(WIDTH));
  assign w_fn_res = w_fn.res[WIDTH-1:0];
  assign w_amt    = i_b[SHW-1:0];

  // Classify the incoming op and derive the iterator set-up.
  always_comb begin
    w_is_shift = (i_op_code == OP_SLL) || (i_op_code == OP_SRL) || (i_op_code == OP_SRA);
`ifdef ALU_MC_MUL_EN
    w_is_mul   = (i_op_code == OP_MUL);
`else
    w_is_mul   = 1'b0;
`endif
    w_multi    = (w_is_shift && (w_amt != '0)) || w_is_mul;
    case (i_op_code)
      OP_SLL:  w_mode = IT_SLL;
      OP_SRL:  w_mode = IT_SRL;
      OP_SRA:  w_mode = IT_SRA;
      default: w_mode = IT_MUL;
    endcase
    w_cnt = w_is_mul ? CW'(WIDTH) : CW'(w_amt);
  end

  assign w_load = (r_state == ST_IDLE) && i_in_valid && w_multi;
  assign w_step = (r_state == ST_EXEC);

  alu_mc_iter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_mode     (w_mode),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_cnt      (w_cnt),
    .o_acc_next (w_acc_next),
    .o_last     (w_last)
  );

  // Control FSM with registered handshake outputs and result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_in_ready <= 1'b0;
            if (w_multi) begin
              r_state <= ST_EXEC;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_fn_res;
              r_zero      <= w_fn.legal && (w_fn_res == '0);
              r_carry     <= w_fn.carry;
              r_ovf       <= w_fn.ovf;
            end
          end
        end
        ST_EXEC: begin
          if (w_last) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_acc_next;
            r_zero      <= (w_acc_next == '0);
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_zero      = r_zero;
  assign o_carry     = r_carry;
  assign o_overflow  = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector bench for alu_mc (WIDTH=32). Expectations for
// op 11 follow whether ALU_MC_MUL_EN is defined for the build.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op_code;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;
  state_t       dbg_state;

  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .i_op_code   (op_code),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_result    (result),
    .o_zero      (zero),
    .o_carry     (carry),
    .o_overflow  (overflow),
    .o_dbg_state (dbg_state)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Present one op at a negedge and hold it for the accepting posedge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_send", W'(in_ready), W'(1));
    op_code  = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    op_code  = 4'($urandom_range(0, 15));
  endtask

  // Count negedges from accept until out_valid; bounded.
  task automatic wait_out(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    chk({tag, "_latency"}, W'(lat), W'(exp_lat));
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] er,
                           input logic ez, input logic ec, input logic ev);
    chk({tag, "_result"}, result, er);
    chk({tag, "_zero"}, W'(zero), W'(ez));
    chk({tag, "_carry"}, W'(carry), W'(ec));
    chk({tag, "_overflow"}, W'(overflow), W'(ev));
  endtask

  // Consume the result and confirm the return to IDLE.
  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_out_valid_drop"}, W'(out_valid), W'(0));
    chk({tag, "_in_ready_back"}, W'(in_ready), W'(1));
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [W-1:0] va, input logic [W-1:0] vb, input int lat,
                        input logic [W-1:0] er, input logic ez, input logic ec, input logic ev);
    send(op, va, vb);
    wait_out(tag, lat);
    check_out(tag, er, ez, ec, ev);
    consume(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] held;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op_code   = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    check_out("rst", '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // arithmetic and flags
    run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1, 1, 0);
    run_op("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 0, 0, 1);
    run_op("sub_ovf",  OP_SUB, 32'h8000_0000, 32'h1, 1, 32'h7FFF_FFFF, 0, 0, 1);
    run_op("sub_brw",  OP_SUB, 32'h3, 32'h5, 1, 32'hFFFF_FFFE, 0, 1, 0);
    run_op("slt_lt",   OP_SLT, 32'h3, 32'h5, 1, 32'h1, 0, 0, 0);
    run_op("slt_ge",   OP_SLT, 32'h5, 32'h3, 1, 32'h0, 1, 0, 0);
    // logic ops
    run_op("mov",      OP_MOV, 32'hCAFE_F00D, 32'h1, 1, 32'hCAFE_F00D, 0, 0, 0);
    run_op("not",      OP_NOT, 32'hFFFF_0000, 32'h0, 1, 32'h0000_FFFF, 0, 0, 0);
    run_op("or",       OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, 1, 32'hF0F0_0F0F, 0, 0, 0);
    run_op("and",      OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'h0F00_0F00, 0, 0, 0);
    run_op("xor_self", OP_XOR, 32'h1234_5678, 32'h1234_5678, 1, 32'h0, 1, 0, 0);
    // shifts: amount is b[4:0]
    run_op("sll_5",    OP_SLL, 32'h1, 32'h25, 6, 32'h20, 0, 0, 0);
    run_op("sra_31",   OP_SRA, 32'h8000_0000, 32'd31, 32, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("srl_4",    OP_SRL, 32'h8000_00F0, 32'd4, 5, 32'h0800_000F, 0, 0, 0);
    run_op("srl_0",    OP_SRL, 32'h0000_1234, 32'h40, 1, 32'h0000_1234, 0, 0, 0);
    run_op("sll_out",  OP_SLL, 32'h8000_0000, 32'd1, 2, 32'h0, 1, 0, 0);
    // illegal opcode
    run_op("ill_13",   4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0, 0, 0, 0);
    // multiply
`ifdef ALU_MC_MUL_EN
    run_op("mul",      OP_MUL, 32'h0001_0001, 32'h0001_0001, 33, 32'h0002_0001, 0, 0, 0);
    run_op("mul_wrap", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001, 0, 0, 0);
`else
    run_op("mul_off",  OP_MUL, 32'h0001_0001, 32'h0001_0001, 1, 32'h0, 0, 0, 0);
`endif

    // backpressure: result held, new requests refused
    send(OP_ADD, 32'd2, 32'd3);
    wait_out("bp", 1);
    held = result;
    for (int i = 0; i < 5; i++) begin
      op_code  = OP_MOV;
      a        = 32'hDEAD_BEEF;
      in_valid = (i % 2) == 0;
      @(negedge clk);
      chk("bp_result_held", result, 32'd5);
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_in_ready_low", W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    chk("bp_held_vs_first", result, held);
    consume("bp");
    @(negedge clk);
    chk("bp_no_stray_accept", W'(out_valid), W'(0));
    run_op("bp_after", OP_ADD, 32'd10, 32'd20, 1, 32'd30, 0, 0, 0);

    // load a result so the abort has something to clear, then abort mid-op
    send(OP_MOV, 32'hA5A5_A5A5, 32'h0);
    wait_out("pre_abort", 1);
    consume("pre_abort");
`ifdef ALU_MC_MUL_EN
    send(OP_MUL, 32'h0001_0001, 32'h0001_0001);
`else
    send(OP_SRA, 32'h8000_0000, 32'd31);
`endif
    repeat (9) @(negedge clk);
    chk("abort_not_done_yet", W'(out_valid), W'(0));
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_result", result, 32'h0);
    chk("abort_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_result", W'(out_valid), W'(0));
    run_op("add_after_rst", OP_ADD, 32'd100, 32'd23, 1, 32'd123, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
